noc_input_vc_buffer: RTL and testbench
======================================

Name: noc_input_vc_buffer

Overview:
- Per-input-port buffer stage of the 4x4 mesh router. It sits directly upstream of the five per-output round-robin arbiters.
- Holds incoming flits in two virtual-channel FIFOs, selected by flit bit 63: even VC 0, odd VC 1.
- Computes the XY route of the head flit of the VC selected by `polarity` and drives one request line toward the matching output arbiter.
- Pops that head on grant and presents the flit with its hop count decremented.

Parameters:
- DEPTH, 2, entries per VC FIFO; power of two, ≥ 1.
- FLIT_W, 64, flit width in bits; must be 64, because the field positions below are fixed.

Ports:
- clk  in  1  router clock
- reset  in  1  asynchronous, active-high reset
- polarity  in  1  current VC phase; 0 = VC 0 forwards, 1 = VC 1 forwards
- in_valid  in  1  upstream flit valid
- in_flit  in  64  upstream flit
- in_ready  out  2  per-VC space available; bit v = VC v not full
- req_e, req_w, req_n, req_s, req_l  out  1 each  request to the east/west/north/south/local output arbiter
- gnt  in  1  OR of this port's grant lines from all five output arbiters
- out_flit  out  64  head flit of VC[polarity], hop field updated
- err_spurious  out  1  sticky: gnt seen while no request was asserted

Behaviour:
- Flit fields:
  - [63] vc
  - [62] dir_x (0 = east, 1 = west)
  - [61] dir_y (0 = north, 1 = south)
  - [60:56] reserved, passed through
  - [55:52] hop_x
  - [51:48] hop_y
  - [47:0] passed through
- Reset: asynchronous, clears both FIFOs (pointers and counts to 0) and err_spurious.
  - While reset is held and after release: in_ready=2'b11, all req_* = 0, out_flit = 0 when the selected VC is empty.
- Write:
  - On a clk edge with in_valid=1 and in_ready[in_flit[63]]=1, the flit is pushed into VC in_flit[63].
  - in_valid with the target VC full: the flit is dropped. This is an upstream protocol violation and is asserted in verification.
  - Writes to either VC are allowed regardless of polarity.
- Read side is combinational from the head of VC p = polarity.
- Routing, evaluated only when VC p is non-empty; exactly one request is asserted:
  - hop_x != 0: req_e if dir_x = 0, req_w if dir_x = 1.
  - else hop_y != 0: req_n if dir_y = 0, req_s if dir_y = 1.
  - else: req_l.
- VC p empty: all req_* = 0 and out_flit = 0.
- out_flit is the head flit with the field actually routed on decremented by 1, modulo 4 bits:
  - hop_x when routing on X;
  - hop_y when routing on Y;
  - unchanged for local.
- Pop:
  - On a clk edge with gnt=1 and any req_* = 1, VC p's read pointer advances (wraps at DEPTH) and its count decrements.
  - Grant-to-pop latency is 0 cycles: the flit is consumed on the same edge.
- Spurious grant: gnt=1 with no request sets err_spurious. The FIFO is unchanged.
- Simultaneous push and pop on the same VC: the count is unchanged and both pointers advance.
  - When that VC was full, in_ready[v] remains 0 during that cycle. Ready is derived from the registered count only and is never combinationally dependent on gnt.
- Polarity toggling mid-packet is legal. The non-selected VC holds its contents, and its head is re-evaluated when selected again.
- Count width is clog2(DEPTH)+1. Full means count == DEPTH; empty means count == 0.
- No output of this block is combinationally dependent on in_valid or in_flit.

Decomposition:
- Shared router package holds:
  - flit field bit-position constants (VC_BIT, DIRX_BIT, DIRY_BIT, HOPX_MSB/LSB, HOPY_MSB/LSB);
  - the output-direction enum (E, W, N, S, L).
- One sub-module, noc_vc_fifo: a single-clock FIFO with push, pop, head, count, full and empty, instantiated twice.
- Route compute and hop decrement stay in the top level as combinational logic.

Test Plan:
- Reset: assert reset mid-stream with 2 flits in VC 0 -> immediately in_ready=2'b11, all req_* = 0, out_flit = 0, err_spurious = 0.
- Routing: polarity=0, push a VC 0 flit with hop_x=3, dir_x=1, hop_y=2 -> req_w=1 only, out_flit[55:52]=2, [51:48]=2. Assert gnt -> empty next cycle, req_w=0.
- Y and local routing, VC 1:
  - flit with hop_x=0, hop_y=1, dir_y=0 -> req_n, out hop_y=0;
  - then a flit with hop_x=0, hop_y=0 -> req_l, out_flit equals the input flit.
- Full and simultaneous:
  - DEPTH=2; fill VC 0 -> in_ready[0]=0 while in_ready[1]=1.
  - Same cycle gnt plus push to VC 1 -> VC 0 count becomes 1, VC 1 count becomes 1, FIFO order preserved.
- Polarity isolation: VC 0 holds flit A and VC 1 holds flit B.
  - polarity=0 shows A; polarity=1 shows B.
  - gnt while polarity=1 pops only B; A is still present when polarity returns to 0.
- Spurious grant: both VCs empty, gnt=1 for 1 cycle -> err_spurious=1 and stays 1; pointers unchanged. A subsequent push/pop works normally.

Source files
------------

// File: rtl/noc_input_vc_buffer_pkg.sv
// Shared router definitions: fixed flit field positions and output directions.
package noc_input_vc_buffer_pkg;

   localparam int unsigned NUM_VC   = 2;
   localparam int unsigned VC_BIT   = 63;
   localparam int unsigned DIRX_BIT = 62;
   localparam int unsigned DIRY_BIT = 61;
   localparam int unsigned HOPX_MSB = 55;
   localparam int unsigned HOPX_LSB = 52;
   localparam int unsigned HOPY_MSB = 51;
   localparam int unsigned HOPY_LSB = 48;
   localparam int unsigned HOP_W    = HOPX_MSB - HOPX_LSB + 1;

   typedef logic [HOP_W-1:0] hop_t;

   typedef enum logic [2:0] {
      DIR_E,
      DIR_W,
      DIR_N,
      DIR_S,
      DIR_L
   } dir_e;

endpackage

// File: rtl/noc_input_vc_buffer_if.sv
// Flit-in / request-out bundle between an input port buffer and its neighbours.
interface noc_input_vc_buffer_if
   import noc_input_vc_buffer_pkg::*;
#(
   parameter int unsigned FLIT_W = 64
);
   logic              polarity;
   logic              in_valid;
   logic [FLIT_W-1:0] in_flit;
   logic [NUM_VC-1:0] in_ready;
   logic              req_e;
   logic              req_w;
   logic              req_n;
   logic              req_s;
   logic              req_l;
   logic              gnt;
   logic [FLIT_W-1:0] out_flit;
   logic              err_spurious;

   modport master (
      output polarity, in_valid, in_flit, gnt,
      input  in_ready, req_e, req_w, req_n, req_s, req_l, out_flit, err_spurious
   );

   modport slave (
      input  polarity, in_valid, in_flit, gnt,
      output in_ready, req_e, req_w, req_n, req_s, req_l, out_flit, err_spurious
   );
endinterface

// File: rtl/noc_vc_fifo.sv
// Single-clock FIFO for one virtual channel; push is ignored when full, pop when empty.
module noc_vc_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned W     = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [W-1:0]           din,
   input  logic                   pop,
   output logic [W-1:0]           head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // storage carries no reset; only entries below count are ever observed
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_next(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (do_pop && !do_push) count <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/noc_input_vc_buffer.sv
// Input port stage: two VC FIFOs, XY route of the selected head, pop on grant.
module noc_input_vc_buffer
   import noc_input_vc_buffer_pkg::*;
#(
   parameter int unsigned DEPTH  = 2,
   parameter int unsigned FLIT_W = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   noc_input_vc_buffer_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [NUM_VC-1:0] push;
   logic [NUM_VC-1:0] pop;
   logic [NUM_VC-1:0] full;
   logic [NUM_VC-1:0] empty;
   logic [FLIT_W-1:0] head  [NUM_VC];
   logic [CNT_W-1:0]  count [NUM_VC];
   logic              in_vc;
   logic [FLIT_W-1:0] sel_head;
   logic              any_req;
   logic              grant_pop;
   logic [FLIT_W-1:0] routed;
   dir_e              dir;
   hop_t              hop_x;
   hop_t              hop_y;
   logic              err_q;
   logic              unused_count;

   assign in_vc     = bus.in_flit[VC_BIT];
   assign sel_head  = head[bus.polarity];
   assign any_req   = !empty[bus.polarity];
   assign grant_pop = bus.gnt && any_req;

   for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
      assign push[v] = bus.in_valid && (in_vc == 1'(v)) && !full[v];
      assign pop[v]  = grant_pop && (bus.polarity == 1'(v));

      noc_vc_fifo #(.DEPTH(DEPTH), .W(FLIT_W)) u_fifo (
         .clk   (clk),
         .reset (reset),
         .push  (push[v]),
         .din   (bus.in_flit),
         .pop   (pop[v]),
         .head  (head[v]),
         .count (count[v]),
         .full  (full[v]),
         .empty (empty[v])
      );
   end

   assign unused_count = ^{count[0], count[1]};

   // ready comes from registered occupancy only, never from gnt
   assign bus.in_ready = ~full;

   // XY routing: exhaust X hops first, then Y, then eject locally
   always_comb begin
      dir    = DIR_L;
      routed = sel_head;
      hop_x  = sel_head[HOPX_MSB:HOPX_LSB];
      hop_y  = sel_head[HOPY_MSB:HOPY_LSB];
      if (hop_x != '0) begin
         dir = sel_head[DIRX_BIT] ? DIR_W : DIR_E;
         routed[HOPX_MSB:HOPX_LSB] = hop_x - HOP_W'(1);
      end else if (hop_y != '0) begin
         dir = sel_head[DIRY_BIT] ? DIR_S : DIR_N;
         routed[HOPY_MSB:HOPY_LSB] = hop_y - HOP_W'(1);
      end
   end

   assign bus.req_e    = any_req && (dir == DIR_E);
   assign bus.req_w    = any_req && (dir == DIR_W);
   assign bus.req_n    = any_req && (dir == DIR_N);
   assign bus.req_s    = any_req && (dir == DIR_S);
   assign bus.req_l    = any_req && (dir == DIR_L);
   assign bus.out_flit = any_req ? routed : '0;

   // sticky flag for a grant arriving with nothing requested
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                     err_q <= 1'b0;
      else if (bus.gnt && !any_req)  err_q <= 1'b1;
   end

   assign bus.err_spurious = err_q;

endmodule

// File: tb/tb_noc_input_vc_buffer.sv
// Self-checking bench for noc_input_vc_buffer: directed scenarios plus randomized traffic vs a queue model.
module tb_noc_input_vc_buffer;
   localparam int unsigned DEPTH = 2;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   noc_input_vc_buffer_if #(.FLIT_W(64)) bus ();

   noc_input_vc_buffer #(.DEPTH(DEPTH), .FLIT_W(64)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   wire [4:0] reqv = {bus.req_e, bus.req_w, bus.req_n, bus.req_s, bus.req_l};

   logic [63:0] q0[$];
   logic [63:0] q1[$];
   bit          m_err;

   function automatic logic [63:0] mk(bit vc, bit dx, bit dy, logic [3:0] hx, logic [3:0] hy);
      logic [63:0] f;
      f = {$urandom, $urandom};
      f[63] = vc; f[62] = dx; f[61] = dy; f[55:52] = hx; f[51:48] = hy;
      return f;
   endfunction

   function automatic logic [63:0] xform(logic [63:0] f);
      logic [63:0] r;
      r = f;
      if (f[55:52] != 4'd0)      r[55:52] = f[55:52] - 4'd1;
      else if (f[51:48] != 4'd0) r[51:48] = f[51:48] - 4'd1;
      return r;
   endfunction

   // one-hot order {e,w,n,s,l}
   function automatic logic [4:0] route(logic [63:0] f);
      if (f[55:52] != 4'd0) return f[62] ? 5'b01000 : 5'b10000;
      if (f[51:48] != 4'd0) return f[61] ? 5'b00010 : 5'b00100;
      return 5'b00001;
   endfunction

   function automatic bit m_empty();
      return bus.polarity ? (q1.size() == 0) : (q0.size() == 0);
   endfunction

   function automatic logic [63:0] m_front();
      return bus.polarity ? q1[0] : q0[0];
   endfunction

   // advance the reference model by one edge using the currently driven inputs, then clock
   task automatic tick();
      int n0, n1;
      bit pe;
      n0 = q0.size();
      n1 = q1.size();
      pe = bus.polarity ? (n1 == 0) : (n0 == 0);
      if (bus.gnt) begin
         if (pe) m_err = 1'b1;
         else if (bus.polarity) void'(q1.pop_front());
         else void'(q0.pop_front());
      end
      if (bus.in_valid) begin
         if (bus.in_flit[63]) begin
            if (n1 < int'(DEPTH)) q1.push_back(bus.in_flit);
         end else begin
            if (n0 < int'(DEPTH)) q0.push_back(bus.in_flit);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push1(logic [63:0] f);
      bus.in_valid = 1'b1;
      bus.in_flit  = f;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic grant1();
      bus.gnt = 1'b1;
      tick();
      bus.gnt = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      total++; if (bus.in_ready !== 2'b11) begin bad++; $display("FAIL reset_held_ready got=%b exp=11", bus.in_ready); end
      total++; if (reqv !== 5'b0) begin bad++; $display("FAIL reset_held_req got=%b exp=00000", reqv); end
      reset = 1'b0;
      bus.polarity = 1'b0;
      push1(mk(1'b0, 1'b0, 1'b0, 4'd1, 4'd0));
      push1(mk(1'b0, 1'b1, 1'b1, 4'd2, 4'd2));
      total++; if (reqv !== 5'b10000) begin bad++; $display("FAIL pre_reset_req got=%b exp=10000", reqv); end
      #2 reset = 1'b1;
      #1;
      total++; if (bus.in_ready !== 2'b11) begin bad++; $display("FAIL reset_ready got=%b exp=11", bus.in_ready); end
      total++; if (reqv !== 5'b0) begin bad++; $display("FAIL reset_req got=%b exp=00000", reqv); end
      total++; if (bus.out_flit !== 64'd0) begin bad++; $display("FAIL reset_out got=%h exp=0", bus.out_flit); end
      total++; if (bus.err_spurious !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.err_spurious); end
      q0.delete(); q1.delete(); m_err = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      #1;
      total++; if (bus.in_ready !== 2'b11 || reqv !== 5'b0) begin bad++; $display("FAIL post_reset got ready=%b req=%b exp 11/00000", bus.in_ready, reqv); end
   endtask

   task automatic test_route_x();
      logic [63:0] f, e;
      bus.polarity = 1'b0;
      f = mk(1'b0, 1'b1, 1'b0, 4'd3, 4'd2);
      e = f; e[55:52] = 4'd2;
      push1(f);
      total++; if (reqv !== 5'b01000) begin bad++; $display("FAIL route_x_req got=%b exp=01000", reqv); end
      total++; if (bus.out_flit[55:52] !== 4'd2 || bus.out_flit[51:48] !== 4'd2) begin bad++; $display("FAIL route_x_hops got=%h/%h exp=2/2", bus.out_flit[55:52], bus.out_flit[51:48]); end
      total++; if (bus.out_flit !== e) begin bad++; $display("FAIL route_x_out got=%h exp=%h", bus.out_flit, e); end
      grant1();
      total++; if (reqv !== 5'b0 || bus.out_flit !== 64'd0) begin bad++; $display("FAIL route_x_pop got req=%b out=%h exp 00000/0", reqv, bus.out_flit); end
   endtask

   task automatic test_y_local();
      logic [63:0] a, b, ea;
      bus.polarity = 1'b1;
      a = mk(1'b1, 1'b0, 1'b0, 4'd0, 4'd1);
      b = mk(1'b1, 1'b1, 1'b1, 4'd0, 4'd0);
      ea = a; ea[51:48] = 4'd0;
      push1(a);
      push1(b);
      total++; if (reqv !== 5'b00100) begin bad++; $display("FAIL route_y_req got=%b exp=00100", reqv); end
      total++; if (bus.out_flit !== ea) begin bad++; $display("FAIL route_y_out got=%h exp=%h", bus.out_flit, ea); end
      grant1();
      total++; if (reqv !== 5'b00001) begin bad++; $display("FAIL route_l_req got=%b exp=00001", reqv); end
      total++; if (bus.out_flit !== b) begin bad++; $display("FAIL route_l_out got=%h exp=%h", bus.out_flit, b); end
      grant1();
      total++; if (reqv !== 5'b0) begin bad++; $display("FAIL y_local_drain got=%b exp=00000", reqv); end
   endtask

   task automatic test_full_simul();
      logic [63:0] c, d, e, ed, ee;
      bus.polarity = 1'b0;
      c = mk(1'b0, 1'b0, 1'b0, 4'd1, 4'd0);
      d = mk(1'b0, 1'b1, 1'b0, 4'd2, 4'd0);
      e = mk(1'b1, 1'b0, 1'b1, 4'd0, 4'd3);
      ed = d; ed[55:52] = 4'd1;
      ee = e; ee[51:48] = 4'd2;
      push1(c);
      push1(d);
      total++; if (bus.in_ready !== 2'b10) begin bad++; $display("FAIL full_ready got=%b exp=10", bus.in_ready); end
      bus.gnt = 1'b1; bus.in_valid = 1'b1; bus.in_flit = e;
      tick();
      bus.gnt = 1'b0; bus.in_valid = 1'b0;
      total++; if (bus.in_ready !== 2'b11) begin bad++; $display("FAIL simul_ready got=%b exp=11", bus.in_ready); end
      total++; if (bus.out_flit !== ed || reqv !== 5'b01000) begin bad++; $display("FAIL simul_order got=%h req=%b exp=%h/01000", bus.out_flit, reqv, ed); end
      bus.polarity = 1'b1;
      #1;
      total++; if (bus.out_flit !== ee || reqv !== 5'b00010) begin bad++; $display("FAIL simul_vc1 got=%h req=%b exp=%h/00010", bus.out_flit, reqv, ee); end
      grant1();
      bus.polarity = 1'b0;
      grant1();
      total++; if (reqv !== 5'b0 || bus.in_ready !== 2'b11) begin bad++; $display("FAIL full_drain got req=%b ready=%b exp 00000/11", reqv, bus.in_ready); end
   endtask

   task automatic test_polarity();
      logic [63:0] a, b, ea, eb;
      a = mk(1'b0, 1'b0, 1'b1, 4'd0, 4'd2);
      b = mk(1'b1, 1'b1, 1'b0, 4'd4, 4'd0);
      ea = a; ea[51:48] = 4'd1;
      eb = b; eb[55:52] = 4'd3;
      bus.polarity = 1'b0;
      push1(a);
      push1(b);
      total++; if (bus.out_flit !== ea || reqv !== 5'b00010) begin bad++; $display("FAIL pol0_view got=%h req=%b exp=%h/00010", bus.out_flit, reqv, ea); end
      bus.polarity = 1'b1;
      #1;
      total++; if (bus.out_flit !== eb || reqv !== 5'b01000) begin bad++; $display("FAIL pol1_view got=%h req=%b exp=%h/01000", bus.out_flit, reqv, eb); end
      grant1();
      total++; if (bus.out_flit !== 64'd0 || reqv !== 5'b0) begin bad++; $display("FAIL pol1_popped got=%h req=%b exp=0/00000", bus.out_flit, reqv); end
      bus.polarity = 1'b0;
      #1;
      total++; if (bus.out_flit !== ea || reqv !== 5'b00010) begin bad++; $display("FAIL pol0_kept got=%h req=%b exp=%h/00010", bus.out_flit, reqv, ea); end
      grant1();
   endtask

   task automatic test_spurious();
      logic [63:0] f, ef;
      bus.polarity = 1'b0;
      total++; if (bus.err_spurious !== 1'b0) begin bad++; $display("FAIL spur_before got=%b exp=0", bus.err_spurious); end
      grant1();
      total++; if (bus.err_spurious !== 1'b1) begin bad++; $display("FAIL spur_set got=%b exp=1", bus.err_spurious); end
      total++; if (bus.in_ready !== 2'b11 || reqv !== 5'b0) begin bad++; $display("FAIL spur_fifo got ready=%b req=%b exp 11/00000", bus.in_ready, reqv); end
      tick();
      total++; if (bus.err_spurious !== 1'b1) begin bad++; $display("FAIL spur_sticky got=%b exp=1", bus.err_spurious); end
      f = mk(1'b0, 1'b0, 1'b1, 4'd0, 4'd5);
      ef = f; ef[51:48] = 4'd4;
      push1(f);
      total++; if (bus.out_flit !== ef || reqv !== 5'b00010) begin bad++; $display("FAIL spur_after_push got=%h req=%b exp=%h/00010", bus.out_flit, reqv, ef); end
      grant1();
      total++; if (reqv !== 5'b0 || bus.err_spurious !== 1'b1) begin bad++; $display("FAIL spur_after_pop got req=%b err=%b exp 00000/1", reqv, bus.err_spurious); end
   endtask

   task automatic test_random();
      logic [63:0] f;
      logic [4:0]  er;
      logic [63:0] eo;
      logic [1:0]  ey;
      bit          vc;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(3) == 0) bus.polarity = ~bus.polarity;
         vc = 1'($urandom_range(1));
         f = mk(vc, 1'($urandom_range(1)), 1'($urandom_range(1)),
                ($urandom_range(2) == 0) ? 4'd0 : 4'($urandom_range(15)),
                ($urandom_range(2) == 0) ? 4'd0 : 4'($urandom_range(15)));
         bus.in_flit  = f;
         bus.in_valid = ($urandom_range(1) == 1) && ((vc ? q1.size() : q0.size()) < int'(DEPTH));
         bus.gnt      = 1'($urandom_range(1));
         #1;
         er = m_empty() ? 5'b0 : route(m_front());
         eo = m_empty() ? 64'd0 : xform(m_front());
         ey = {q1.size() < int'(DEPTH), q0.size() < int'(DEPTH)};
         total++; if (bus.in_ready !== ey) begin bad++; $display("FAIL rnd_ready i=%0d got=%b exp=%b", i, bus.in_ready, ey); end
         total++; if (reqv !== er) begin bad++; $display("FAIL rnd_req i=%0d got=%b exp=%b", i, reqv, er); end
         total++; if (bus.out_flit !== eo) begin bad++; $display("FAIL rnd_out i=%0d got=%h exp=%h", i, bus.out_flit, eo); end
         total++; if (bus.err_spurious !== m_err) begin bad++; $display("FAIL rnd_err i=%0d got=%b exp=%b", i, bus.err_spurious, m_err); end
         tick();
      end
      bus.in_valid = 1'b0;
      bus.gnt      = 1'b0;
   endtask

   initial begin
      reset        = 1'b1;
      bus.polarity = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_flit  = 64'd0;
      bus.gnt      = 1'b0;
      m_err        = 1'b0;
      test_reset();
      test_route_x();
      test_y_local();
      test_full_simul();
      test_polarity();
      test_spurious();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
